// File: rtl/iic_monitor.sv
// ---------------------------------------------------------------------------
// iic_monitor
// Listen-only IIC write decoder. It watches an IIC bus, accepts write
// transactions addressed to CHIP_ADDR and reports every data byte, together
// with the register address it targets, as a one-cycle pulse. The register
// pointer auto-increments so a burst write reports consecutive addresses.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   rstn       : asynchronous active-low reset
//   scl, sda   : IIC bus lines, asynchronous to clk, never driven
//   reg_addr   : register address of the most recent data byte
//   reg_data   : most recent data byte
//   data_valid : one-clk pulse, reg_addr/reg_data update in the same cycle
//   addr_err   : one-clk pulse when the address byte is not CHIP_ADDR
//   busy       : high whenever a transaction is being tracked (not IDLE)
// ---------------------------------------------------------------------------
module iic_monitor #(
    parameter logic [7:0] CHIP_ADDR = 8'hD0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl,
    input  logic       sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       data_valid,
    output logic       addr_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHIP      = 3'd1,
        S_REG       = 3'd2,
        S_DATA      = 3'd3,
        S_WAIT_STOP = 3'd4
    } state_t;

    // Two synchronizer stages plus one history stage per bus line.
    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_ptr;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_data;
    logic       r_data_valid;
    logic       r_addr_err;

    logic       w_start;
    logic       w_stop;
    logic       w_bit_edge;
    logic       w_tracking;

    // START/STOP need scl high in both samples, while a bit edge needs the
    // previous scl sample low, so an sda change coincident with an scl rise
    // can only ever be taken as a bit.
    assign w_start    = r_scl_s2 && r_scl_d && !r_sda_s2 &&  r_sda_d;
    assign w_stop     = r_scl_s2 && r_scl_d &&  r_sda_s2 && !r_sda_d;
    assign w_bit_edge = r_scl_s2 && !r_scl_d;

    // Only the byte-collecting states count bits; IDLE and WAIT_STOP ignore them.
    assign w_tracking = (r_state == S_CHIP) || (r_state == S_REG) || (r_state == S_DATA);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scl_s1     <= 1'b1;
            r_scl_s2     <= 1'b1;
            r_scl_d      <= 1'b1;
            r_sda_s1     <= 1'b1;
            r_sda_s2     <= 1'b1;
            r_sda_d      <= 1'b1;
            r_state      <= S_IDLE;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'h00;
            r_ptr        <= 8'h00;
            r_reg_addr   <= 8'h00;
            r_reg_data   <= 8'h00;
            r_data_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_scl_s1     <= scl;
            r_scl_s2     <= r_scl_s1;
            r_scl_d      <= r_scl_s2;
            r_sda_s1     <= sda;
            r_sda_s2     <= r_sda_s1;
            r_sda_d      <= r_sda_s2;

            r_data_valid <= 1'b0;
            r_addr_err   <= 1'b0;

            if (w_start) begin
                // Covers repeated START too: any partial byte is discarded.
                r_state   <= S_CHIP;
                r_bit_cnt <= 4'd0;
                r_shift   <= 8'h00;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 4'd0;
                r_shift   <= 8'h00;
            end else if (w_bit_edge && w_tracking) begin
                if (r_bit_cnt == 4'd8) begin
                    // 9th (ACK) bit: the byte in r_shift is complete.
                    r_bit_cnt <= 4'd0;
                    case (r_state)
                        S_CHIP: begin
                            if (r_shift == CHIP_ADDR) begin
                                r_state <= S_REG;
                            end else begin
                                r_addr_err <= 1'b1;
                                r_state    <= S_WAIT_STOP;
                            end
                        end
                        S_REG: begin
                            r_ptr   <= r_shift;
                            r_state <= S_DATA;
                        end
                        S_DATA: begin
                            r_reg_addr   <= r_ptr;
                            r_reg_data   <= r_shift;
                            r_data_valid <= 1'b1;
                            r_ptr        <= r_ptr + 8'd1;
                        end
                        default: r_state <= r_state;
                    endcase
                end else begin
                    // Data bits arrive MSB first.
                    r_shift   <= {r_shift[6:0], r_sda_s2};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
        end
    end

    assign reg_addr   = r_reg_addr;
    assign reg_data   = r_reg_data;
    assign data_valid = r_data_valid;
    assign addr_err   = r_addr_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_iic_monitor.sv
// ---------------------------------------------------------------------------
// tb_iic_monitor
// Directed bench for iic_monitor: drives IIC write frames on scl/sda, collects
// data_valid/addr_err pulses with their latency from the 9th scl rise, and
// compares them against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_iic_monitor;

    logic       clk;
    logic       rstn;
    logic       scl;
    logic       sda;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       data_valid;
    logic       addr_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc = 0;
    int          last_rise = 0;
    logic [15:0] dv_q[$];
    int          lat_q[$];
    int          ae_lat_q[$];
    bit          rnd = 1'b0;

    iic_monitor #(.CHIP_ADDR(8'hD0)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .scl        (scl),
        .sda        (sda),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .data_valid (data_valid),
        .addr_err   (addr_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (data_valid) begin
            dv_q.push_back({reg_addr, reg_data});
            lat_q.push_back(cyc - last_rise);
        end
        if (addr_err) ae_lat_q.push_back(cyc - last_rise);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_pulse(input string tag, input int idx, input logic [15:0] exp);
        logic [15:0] got;
        int          lat;
        got = (idx < dv_q.size()) ? dv_q[idx] : 16'hxxxx;
        lat = (idx < lat_q.size()) ? lat_q[idx] : -1;
        check(tag, {16'h0, got}, {16'h0, exp});
        check({tag, "_lat"}, lat, 3);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit ack);
        int lo, hi;
        lo = rnd ? int'($urandom_range(4, 20)) : 6;
        hi = rnd ? int'($urandom_range(4, 20)) : 6;
        sda = b;
        wait_clk(lo - 1);
        scl = 1'b1;
        if (ack) last_rise = cyc;
        wait_clk(hi);
        scl = 1'b0;
        wait_clk(1);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
        send_bit(1'b0, 1'b1);
    endtask

    task automatic send_start();
        sda = 1'b1; wait_clk(6);
        scl = 1'b1; wait_clk(6);
        sda = 1'b0; wait_clk(6);
        scl = 1'b0; wait_clk(6);
    endtask

    task automatic send_stop();
        sda = 1'b0; wait_clk(6);
        scl = 1'b1; wait_clk(6);
        sda = 1'b1; wait_clk(8);
    endtask

    task automatic clear_mon();
        dv_q.delete();
        lat_q.delete();
        ae_lat_q.delete();
    endtask

    initial begin
        logic [7:0] r, d1, d2;
        rstn = 1'b0;
        scl  = 1'b1;
        sda  = 1'b1;
        wait_clk(4);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_reg_data", reg_data, 8'h00);
        check("rst_dv", data_valid, 1'b0);
        check("rst_ae", addr_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rstn = 1'b1;
        wait_clk(4);

        // Single data byte
        clear_mon();
        send_start();
        wait_clk(2);
        check("t1_busy_hi", busy, 1'b1);
        send_byte(8'hD0); send_byte(8'h00); send_byte(8'h9A);
        send_stop();
        check("t1_count", dv_q.size(), 1);
        chk_pulse("t1_p0", 0, 16'h009A);
        check("t1_busy_lo", busy, 1'b0);
        $display("txn t1: D0 00 9A -> %0d pulse(s)", dv_q.size());

        // Burst with pointer wrap
        clear_mon();
        send_start();
        send_byte(8'hD0); send_byte(8'hFF); send_byte(8'h11); send_byte(8'h22);
        send_stop();
        check("t2_count", dv_q.size(), 2);
        chk_pulse("t2_p0", 0, 16'hFF11);
        chk_pulse("t2_p1", 1, 16'h0022);
        $display("txn t2: D0 FF 11 22 -> %0d pulse(s)", dv_q.size());

        // Wrong chip address
        clear_mon();
        send_start();
        send_byte(8'hA0); send_byte(8'h00); send_byte(8'h55);
        send_stop();
        check("t3_ae_count", ae_lat_q.size(), 1);
        check("t3_ae_lat", (ae_lat_q.size() > 0) ? ae_lat_q[0] : -1, 3);
        check("t3_dv_count", dv_q.size(), 0);
        check("t3_reg_addr", reg_addr, 8'h00);
        check("t3_reg_data", reg_data, 8'h22);
        $display("txn t3: A0 00 55 -> %0d addr_err", ae_lat_q.size());

        // Partial byte aborted by repeated START
        clear_mon();
        send_start();
        send_byte(8'hD0); send_byte(8'h05);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_start();
        send_byte(8'hD0); send_byte(8'h07); send_byte(8'h3C);
        send_stop();
        check("t4_count", dv_q.size(), 1);
        chk_pulse("t4_p0", 0, 16'h073C);
        $display("txn t4: repeated start -> %0d pulse(s)", dv_q.size());

        // Reset during the register byte
        clear_mon();
        send_start();
        send_byte(8'hD0);
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        check("t5_rst_addr", reg_addr, 8'h00);
        check("t5_rst_data", reg_data, 8'h00);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_dv", data_valid, 1'b0);
        sda = 1'b1;
        scl = 1'b1;
        wait_clk(3);
        rstn = 1'b1;
        wait_clk(3);
        scl = 1'b0;
        wait_clk(3);
        send_byte(8'hD0); send_byte(8'h00); send_byte(8'h9A);
        check("t5_nostart_count", dv_q.size(), 0);
        check("t5_nostart_busy", busy, 1'b0);
        send_stop();
        send_start();
        send_byte(8'hD0); send_byte(8'h10); send_byte(8'h77);
        send_stop();
        check("t5_count", dv_q.size(), 1);
        chk_pulse("t5_p0", 0, 16'h1077);
        $display("txn t5: reset abort then D0 10 77 -> %0d pulse(s)", dv_q.size());

        // Randomized scl widths
        rnd = 1'b1;
        for (int f = 0; f < 6; f++) begin
            r  = 8'($urandom_range(0, 255));
            d1 = 8'($urandom_range(0, 255));
            d2 = 8'($urandom_range(0, 255));
            clear_mon();
            send_start();
            send_byte(8'hD0); send_byte(r); send_byte(d1); send_byte(d2);
            send_stop();
            check("t6_count", dv_q.size(), 2);
            chk_pulse("t6_p0", 0, {r, d1});
            chk_pulse("t6_p1", 1, {r + 8'd1, d2});
            $display("txn t6.%0d: D0 %02h %02h %02h -> %0d pulse(s)", f, r, d1, d2, dv_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iic_monitor.md
IIC_MONITOR -- requirements
Module: iic_monitor

Interface
REQ-001 Parameter CHIP_ADDR, default 8'hD0, is the 8-bit address byte (7-bit address plus write bit 0) this block accepts.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 scl  input  1  IIC clock from the bus master, asynchronous to clk.
REQ-005 sda  input  1  IIC data from the bus master, asynchronous to clk.
REQ-006 reg_addr  output  8  register address of the most recently written data byte.
REQ-007 reg_data  output  8  most recently received data byte.
REQ-008 data_valid  output  1  one-clk pulse; reg_addr/reg_data are updated in the same cycle.
REQ-009 addr_err  output  1  one-clk pulse when a received address byte is not equal to CHIP_ADDR.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 scl and sda each pass through a 2-flop synchronizer; a third register holds the previous synced sample, and all decoding uses synced values only.
REQ-012 START is synced sda 1->0 while synced scl is high in both current and previous samples; STOP is synced sda 0->1 under the same scl condition.
REQ-013 A bit is sampled on a synced scl 0->1 edge; an sda change in the same cycle as that scl edge is a bit sample, never START or STOP.
REQ-014 The block is listen-only, never drives sda, and treats each byte as 8 data bits MSB-first plus a 9th ACK bit, which is counted and ignored.
REQ-015 The bit counter runs 0..8 and wraps to 0 after the 9th bit; the byte is complete on the 9th bit.
REQ-016 The state machine has the states IDLE, CHIP, REG, DATA and WAIT_STOP.
REQ-017 IDLE: on START go to CHIP; all bit edges are ignored.
REQ-018 CHIP: on byte complete, go to REG if the byte equals CHIP_ADDR; otherwise pulse addr_err and go to WAIT_STOP.
REQ-019 REG: on byte complete, load the byte into the internal address pointer and go to DATA.
REQ-020 DATA: on byte complete, drive reg_addr with the pointer and reg_data with the byte, pulse data_valid, increment the pointer modulo 256 (8'hFF wraps to 8'h00), and stay in DATA (burst write).
REQ-021 WAIT_STOP: ignore bits until START or STOP.
REQ-022 START in any state (including repeated START) goes to CHIP and clears the bit counter and shift register.
REQ-023 STOP in any state goes to IDLE.
REQ-024 A partial byte aborted by START or STOP produces no pulse and leaves reg_addr/reg_data unchanged.
REQ-025 data_valid and addr_err are registered and assert exactly 3 clk rising edges after the 9th scl rising edge at the port.
REQ-026 reg_addr and reg_data hold their value between data_valid pulses.

Reset
REQ-027 While rstn is low, the block asynchronously sets: state IDLE, bit counter 0, shift register 0, pointer 0, reg_addr 8'h00, reg_data 8'h00, data_valid 0, addr_err 0, busy 0, and all synchronizer flops 1 (idle bus).
REQ-028 Reset asserted mid-transfer aborts the transfer; after release, the block ignores bits until the next START.

Verification
REQ-029 START, D0, 00, 9A, STOP -> one data_valid pulse with reg_addr=8'h00 and reg_data=8'h9A; busy falls after STOP.
REQ-030 START, D0, FF, 11, 22, STOP -> two pulses: (8'hFF, 8'h11) then (8'h00, 8'h22).
REQ-031 START, A0, 00, 55, STOP -> one addr_err pulse, no data_valid, and reg_addr/reg_data unchanged.
REQ-032 START, D0, 05, 4 bits, repeated START, D0, 07, 3C, STOP -> exactly one pulse, (8'h07, 8'h3C).
REQ-033 rstn low during the REG byte -> all outputs 0 immediately; an 8-bit pattern sent without START after release produces no pulse; a following full frame decodes normally.
REQ-034 Randomized scl high/low widths of 4..20 clk -> data_valid timing is exactly 3 clk after the 9th scl rise, checked by scoreboard.
